led_frame_scheduler: RTL and testbench

LED_FRAME_SCHEDULER -- requirements
Module: led_frame_scheduler

---
 rtl/led_pkg.sv | 29 ++
 rtl/sched_timer.sv | 38 +++
 rtl/led_frame_scheduler.sv | 145 ++++++++++++++
 tb/tb_led_frame_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and default timing constants for the LED frame scheduler.
package led_pkg;

  localparam int unsigned LATCH_CYCLES_DEF   = 15000;
  localparam int unsigned REFRESH_CYCLES_DEF = 1666667;
  localparam int unsigned BUSY_TIMEOUT_DEF   = 255;
  localparam int unsigned STATE_W            = 3;
  localparam int unsigned DROP_W             = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    SWAP      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    SEND      = 3'd4,
    LATCH     = 3'd5
  } sched_state_t;

  // Saturating subtraction for computing timer reload values.
  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

  // Counter width able to hold 0..p, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned p);
    return ($clog2(p + 1) < 1) ? 1 : $clog2(p + 1);
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable saturating down-counter; done_o is high while the count is zero.
module sched_timer #(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             done_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= RST_VAL;
      done_q  <= (RST_VAL == '0);
    end else begin
      count_q <= count_d;
      done_q  <= (count_d == '0);
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/led_frame_scheduler.sv
// Schedules double-buffer swaps and neopixel driver starts, with latch gap,
// periodic refresh of the last frame and a busy-handshake timeout.
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int unsigned LATCH_CYCLES   = LATCH_CYCLES_DEF,
  parameter int unsigned REFRESH_CYCLES = REFRESH_CYCLES_DEF,
  parameter int unsigned BUSY_TIMEOUT   = BUSY_TIMEOUT_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_enable,
  input  logic               i_frame_done,
  input  logic               i_drv_busy,
  input  logic               i_drv_frame_done,
  output logic               o_swap,
  output logic               o_drv_start,
  output logic [DROP_W-1:0]  o_dropped_cnt,
  output logic               o_timeout,
  output logic [STATE_W-1:0] o_state
);

  localparam int unsigned LAT_W = cnt_width(LATCH_CYCLES);
  localparam int unsigned REF_W = cnt_width(REFRESH_CYCLES);
  localparam int unsigned BSY_W = cnt_width(BUSY_TIMEOUT);

  // Reload values chosen so done is seen on the last cycle of each interval.
  localparam logic [LAT_W-1:0] LAT_LOAD   = LAT_W'(sat_sub(LATCH_CYCLES, 1));
  localparam logic [BSY_W-1:0] BSY_LOAD   = BSY_W'(sat_sub(BUSY_TIMEOUT, 2));
  localparam logic [REF_W-1:0] REF_LOAD   = REF_W'(REFRESH_CYCLES);
  localparam logic             REFRESH_ON = 1'(REFRESH_CYCLES != 0);

  sched_state_t      state_q;
  logic              pending_q;
  logic              shown_q;
  logic              swap_q;
  logic              start_q;
  logic              timeout_q;
  logic [DROP_W-1:0] dropped_q;

  logic lat_done;
  logic ref_done;
  logic bsy_done;
  logic go_swap_c;
  logic go_refresh_c;

  sched_timer #(.WIDTH(LAT_W), .RST_VAL(LAT_W'(0))) u_latch_timer (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (state_q != LATCH),
    .load_val_i (LAT_LOAD),
    .done_o     (lat_done)
  );

  // Refresh down-count from REF_LOAD mirrors an up-count cleared in START.
  sched_timer #(.WIDTH(REF_W), .RST_VAL(REF_LOAD)) u_refresh_timer (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (state_q == START),
    .load_val_i (REF_LOAD),
    .done_o     (ref_done)
  );

  sched_timer #(.WIDTH(BSY_W), .RST_VAL(BSY_W'(0))) u_busy_timer (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (state_q != WAIT_BUSY),
    .load_val_i (BSY_LOAD),
    .done_o     (bsy_done)
  );

  assign go_swap_c    = (state_q == IDLE) && i_enable && pending_q;
  assign go_refresh_c = (state_q == IDLE) && i_enable && !pending_q && shown_q
                        && REFRESH_ON && ref_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      swap_q    <= 1'b0;
      start_q   <= 1'b0;
      shown_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      swap_q  <= go_swap_c;
      start_q <= (state_q == SWAP) || go_refresh_c;
      case (state_q)
        IDLE: begin
          if (go_swap_c) begin
            state_q <= SWAP;
          end else if (go_refresh_c) begin
            state_q <= START;
          end
        end
        SWAP: state_q <= START;
        START: begin
          shown_q <= 1'b1;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (i_drv_busy) begin
            state_q <= SEND;
          end else if (bsy_done) begin
            timeout_q <= 1'b1;
            state_q   <= LATCH;
          end
        end
        SEND: begin
          if (i_drv_frame_done || !i_drv_busy) begin
            state_q <= LATCH;
          end
        end
        LATCH: begin
          if (lat_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A frame landing in the SWAP cycle stays pending for the next swap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_q <= 1'b0;
      dropped_q <= '0;
    end else begin
      if (i_frame_done) begin
        pending_q <= 1'b1;
      end else if (state_q == SWAP) begin
        pending_q <= 1'b0;
      end
      if (i_frame_done && pending_q && (state_q != SWAP) && (dropped_q != '1)) begin
        dropped_q <= dropped_q + DROP_W'(1);
      end
    end
  end

  assign o_swap        = swap_q;
  assign o_drv_start   = start_q;
  assign o_dropped_cnt = dropped_q;
  assign o_timeout     = timeout_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench for led_frame_scheduler with a simple driver model.
module tb_led_frame_scheduler;

  localparam int unsigned LAT = 20;
  localparam int unsigned REF = 1000;
  localparam int unsigned BTO = 16;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_enable;
  logic       i_frame_done;
  logic       i_drv_busy;
  logic       i_drv_frame_done;
  logic       o_swap;
  logic       o_drv_start;
  logic [7:0] o_dropped_cnt;
  logic       o_timeout;
  logic [2:0] o_state;

  always #5 clk = ~clk;

  led_frame_scheduler #(
    .LATCH_CYCLES   (LAT),
    .REFRESH_CYCLES (REF),
    .BUSY_TIMEOUT   (BTO)
  ) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_enable         (i_enable),
    .i_frame_done     (i_frame_done),
    .i_drv_busy       (i_drv_busy),
    .i_drv_frame_done (i_drv_frame_done),
    .o_swap           (o_swap),
    .o_drv_start      (o_drv_start),
    .o_dropped_cnt    (o_dropped_cnt),
    .o_timeout        (o_timeout),
    .o_state          (o_state)
  );

  typedef struct packed { int kind; int cyc; } ev_t;  // kind 0 = swap, 1 = start
  typedef struct {
    int send_frames;
    bit swap_frame;
    int busy_len;
    int exp_drop;
    int exp_swaps;
    int exp_starts;
  } vec_t;

  ev_t sb[$];
  int  start_log[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc, n_swaps, n_starts, latch_run, busy_len, remain;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int lim);
    checks++;
    if (act < lim) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected >= %0d", name, cyc, act, lim);
    end
  endtask

  // One clock: sample outputs after the edge, score events, run driver model.
  task automatic tick();
    ev_t ev;
    @(posedge clk);
    #1;
    cyc++;
    if (o_swap || o_drv_start) begin
      if (o_swap) n_swaps++;
      if (o_drv_start) begin
        n_starts++;
        start_log.push_back(cyc);
      end
      if (sb.size() > 0) begin
        ev = sb.pop_front();
        chk("sb_kind", o_swap ? 0 : 1, ev.kind);
        chk("sb_cycle", cyc, ev.cyc);
      end
    end
    if (o_state == 3'd5) begin
      latch_run++;
    end else if (latch_run > 0) begin
      chk("latch_len", latch_run, LAT);
      latch_run = 0;
    end
    i_drv_frame_done = 1'b0;
    if (o_drv_start && busy_len > 0) begin
      i_drv_busy = 1'b1;
      remain     = busy_len;
    end else if (remain > 0) begin
      remain--;
      if (remain == 0) begin
        i_drv_busy       = 1'b0;
        i_drv_frame_done = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input logic en);
    i_rst = 1'b1;
    i_enable = en;
    i_frame_done = 1'b0;
    i_drv_busy = 1'b0;
    i_drv_frame_done = 1'b0;
    remain = 0;
    tick();
    tick();
    chk("rst_state", int'(o_state), 0);
    chk("rst_dropped", int'(o_dropped_cnt), 0);
    chk("rst_timeout", int'(o_timeout), 0);
    chk("rst_pulses", int'({o_swap, o_drv_start}), 0);
    i_rst = 1'b0;
    cyc = 0;
    n_swaps = 0;
    n_starts = 0;
    latch_run = 0;
    sb.delete();
    start_log.delete();
  endtask

  task automatic push_frame_events(input int n);
    sb.push_back('{kind: 0, cyc: n + 2});
    sb.push_back('{kind: 1, cyc: n + 3});
  endtask

  vec_t vecs[6];

  initial begin
    logic fd;
    vecs[0] = '{0, 1'b0, 100, 0, 1, 1};
    vecs[1] = '{3, 1'b0, 100, 2, 2, 2};
    vecs[2] = '{1, 1'b0,  60, 0, 2, 2};
    vecs[3] = '{2, 1'b0,  60, 1, 2, 2};
    vecs[4] = '{0, 1'b1,  40, 0, 2, 2};
    vecs[5] = '{5, 1'b0,  80, 4, 2, 2};

    // Frame at 10, optional frame in the SWAP cycle, extra frames during SEND.
    for (int r = 0; r < 6; r++) begin
      busy_len = vecs[r].busy_len;
      do_reset(1'b1);
      while (cyc < 400) begin
        fd = 1'b0;
        if (cyc == 10) begin
          fd = 1'b1;
          push_frame_events(cyc);
        end
        if (vecs[r].swap_frame && cyc == 12) fd = 1'b1;
        for (int j = 0; j < vecs[r].send_frames; j++)
          if (cyc == 20 + 8 * j) fd = 1'b1;
        i_frame_done = fd;
        tick();
      end
      chk($sformatf("v%0d_dropped", r), int'(o_dropped_cnt), vecs[r].exp_drop);
      chk($sformatf("v%0d_swaps", r), n_swaps, vecs[r].exp_swaps);
      chk($sformatf("v%0d_starts", r), n_starts, vecs[r].exp_starts);
      chk($sformatf("v%0d_idle", r), int'(o_state), 0);
      chk($sformatf("v%0d_sb_empty", r), sb.size(), 0);
    end

    // Refresh: one frame, then periodic restarts every REF+2 cycles, no swaps.
    busy_len = 30;
    do_reset(1'b1);
    while (cyc < 3500) begin
      i_frame_done = (cyc == 10);
      if (cyc == 10) push_frame_events(cyc);
      tick();
    end
    chk("refresh_starts", n_starts, (3500 - 13) / (REF + 2) + 1);
    chk("refresh_swaps", n_swaps, 1);
    for (int i = 1; i < start_log.size(); i++)
      chk_ge("refresh_interval", start_log[i] - start_log[i-1], REF);

    // Disabled: frames keep pending and saturate the drop count, no sends.
    busy_len = 30;
    do_reset(1'b0);
    while (cyc < 420) begin
      if (cyc == 320) begin
        chk("dis_swaps", n_swaps, 0);
        chk("dis_state", int'(o_state), 0);
        chk("dis_dropped", int'(o_dropped_cnt), 255);
      end
      if (cyc == 330) begin
        i_enable = 1'b1;
        sb.push_back('{kind: 0, cyc: 331});
        sb.push_back('{kind: 1, cyc: 332});
      end
      i_frame_done = (cyc >= 5 && cyc <= 300);
      tick();
    end
    chk("en_swaps", n_swaps, 1);
    chk("en_starts", n_starts, 1);
    chk("en_dropped", int'(o_dropped_cnt), 255);
    chk("en_sb_empty", sb.size(), 0);

    // Timeout: driver never goes busy after the start at cycle 13.
    busy_len = 0;
    do_reset(1'b1);
    while (cyc < 80) begin
      if (cyc == 28) chk("to_before", int'(o_timeout), 0);
      if (cyc == 29) begin
        chk("to_set", int'(o_timeout), 1);
        chk("to_latch", int'(o_state), 5);
      end
      if (cyc == 48) chk("to_latch_end", int'(o_state), 5);
      if (cyc == 49) chk("to_idle", int'(o_state), 0);
      i_frame_done = (cyc == 10);
      if (cyc == 10) push_frame_events(cyc);
      tick();
    end
    chk("to_sticky", int'(o_timeout), 1);

    // Reset in SEND: abandon send, clear counters, no starts until a new frame.
    busy_len = 200;
    do_reset(1'b1);
    while (cyc < 1700) begin
      if (cyc == 49) begin
        chk("rs_in_send", int'(o_state), 4);
        chk("rs_pre_dropped", int'(o_dropped_cnt), 1);
      end
      if (cyc == 51) begin
        chk("rs_state", int'(o_state), 0);
        chk("rs_dropped", int'(o_dropped_cnt), 0);
        chk("rs_timeout", int'(o_timeout), 0);
        i_rst = 1'b0;
        i_drv_busy = 1'b0;
        remain = 0;
        busy_len = 30;
      end
      if (cyc == 1600) begin
        chk("rs_no_start", n_starts, 1);
        chk("rs_no_swap", n_swaps, 1);
        push_frame_events(cyc);
      end
      i_rst = (cyc == 50);
      i_frame_done = (cyc == 10 || cyc == 20 || cyc == 30 || cyc == 1600);
      if (cyc == 10) push_frame_events(cyc);
      tick();
    end
    chk("rs_restart", n_starts, 2);
    chk("rs_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
